// File: rtl/eth_rx_frame_reader.sv
// Receives one header + 8-bit AXI-stream payload from an eth_axis_rx-style master and writes it to a byte RAM.
// Optional EtherType filtering is compiled in with `define ETH_RX_TYPE_FILTER_EN.
module eth_rx_frame_reader #(
  parameter int          ADDR_W      = 8,
  parameter logic [15:0] FILTER_TYPE = 16'h0800
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_eth_hdr_valid,
  output logic              m_eth_hdr_ready,
  input  logic [47:0]       m_eth_dest_mac,
  input  logic [47:0]       m_eth_src_mac,
  input  logic [15:0]       m_eth_type,
  input  logic [7:0]        m_eth_payload_axis_tdata,
  input  logic              m_eth_payload_axis_tvalid,
  output logic              m_eth_payload_axis_tready,
  input  logic              m_eth_payload_axis_tlast,
  input  logic              m_eth_payload_axis_tuser,
  output logic [ADDR_W-1:0] buf_waddr,
  output logic [7:0]        buf_wdata,
  output logic              buf_wen,
  output logic [47:0]       frame_dest_mac,
  output logic [47:0]       frame_src_mac,
  output logic [15:0]       frame_type,
  output logic [ADDR_W:0]   frame_len,
  output logic              frame_err,
  output logic              valid
);

  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    WAIT_HDR,
    RECV,
    DROP,
    DONE
  } state_t;

  state_t              r_state;
  logic                r_filt;
  logic [ADDR_W:0]     r_cnt;
  logic                r_err;
  logic                r_valid;
  logic                r_buf_wen;
  logic [ADDR_W-1:0]   r_buf_waddr;
  logic [7:0]          r_buf_wdata;
  logic [47:0]         r_dest_mac;
  logic [47:0]         r_src_mac;
  logic [15:0]         r_type;

  logic                w_hdr_fire;
  logic                w_beat;
  logic                w_full;
  logic                w_type_ok;

  // Counter stops at buffer capacity so frame_len never wraps on oversize frames.
  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] c);
    return (c == CAP) ? c : c + 1'b1;
  endfunction

`ifdef ETH_RX_TYPE_FILTER_EN
  assign w_type_ok = (m_eth_type == FILTER_TYPE);
`else
  assign w_type_ok = 1'b1;
`endif

  assign m_eth_hdr_ready           = (r_state == WAIT_HDR);
  assign m_eth_payload_axis_tready = (r_state == RECV) || (r_state == DROP);

  assign w_hdr_fire = m_eth_hdr_valid & m_eth_hdr_ready;
  assign w_beat     = m_eth_payload_axis_tvalid & m_eth_payload_axis_tready;
  assign w_full     = (r_cnt == CAP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= WAIT_HDR;
      r_filt      <= 1'b0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_valid     <= 1'b0;
      r_buf_wen   <= 1'b0;
      r_buf_waddr <= '0;
      r_buf_wdata <= '0;
      r_dest_mac  <= '0;
      r_src_mac   <= '0;
      r_type      <= '0;
    end else begin
      r_buf_wen <= 1'b0;
      r_valid   <= 1'b0;
      case (r_state)
        WAIT_HDR: begin
          if (w_hdr_fire) begin
            if (w_type_ok) begin
              r_dest_mac <= m_eth_dest_mac;
              r_src_mac  <= m_eth_src_mac;
              r_type     <= m_eth_type;
              r_cnt      <= '0;
              r_err      <= 1'b0;
              r_filt     <= 1'b0;
              r_state    <= RECV;
            end else begin
              // Filtered frame: drain payload but leave the previous frame's results visible.
              r_filt  <= 1'b1;
              r_state <= DROP;
            end
          end
        end
        RECV: begin
          if (w_beat) begin
            if (!w_full) begin
              r_buf_wen   <= 1'b1;
              r_buf_waddr <= r_cnt[ADDR_W-1:0];
              r_buf_wdata <= m_eth_payload_axis_tdata;
              r_cnt       <= sat_inc(r_cnt);
              if (m_eth_payload_axis_tlast) begin
                r_err   <= r_err | m_eth_payload_axis_tuser;
                r_valid <= 1'b1;
                r_state <= DONE;
              end
            end else begin
              r_err <= 1'b1;
              if (m_eth_payload_axis_tlast) begin
                r_valid <= 1'b1;
                r_state <= DONE;
              end else begin
                r_state <= DROP;
              end
            end
          end
        end
        DROP: begin
          if (w_beat && m_eth_payload_axis_tlast) begin
            if (r_filt) begin
              r_filt  <= 1'b0;
              r_state <= WAIT_HDR;
            end else begin
              r_err   <= r_err | m_eth_payload_axis_tuser;
              r_valid <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_state <= WAIT_HDR;
        end
        default: begin
          r_state <= WAIT_HDR;
        end
      endcase
    end
  end

  assign buf_wen        = r_buf_wen;
  assign buf_waddr      = r_buf_waddr;
  assign buf_wdata      = r_buf_wdata;
  assign frame_dest_mac = r_dest_mac;
  assign frame_src_mac  = r_src_mac;
  assign frame_type     = r_type;
  assign frame_len      = r_cnt;
  assign frame_err      = r_err;
  assign valid          = r_valid;

endmodule

// File: tb/tb_eth_rx_frame_reader.sv
// Directed bench for eth_rx_frame_reader with a 16-byte buffer (ADDR_W=4).
module tb_eth_rx_frame_reader;

  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              hdr_valid = 1'b0;
  logic              hdr_ready;
  logic [47:0]       dest_mac = '0;
  logic [47:0]       src_mac = '0;
  logic [15:0]       eth_type = '0;
  logic [7:0]        tdata = '0;
  logic              tvalid = 1'b0;
  logic              tready;
  logic              tlast = 1'b0;
  logic              tuser = 1'b0;
  logic [ADDR_W-1:0] buf_waddr;
  logic [7:0]        buf_wdata;
  logic              buf_wen;
  logic [47:0]       frame_dest_mac;
  logic [47:0]       frame_src_mac;
  logic [15:0]       frame_type;
  logic [ADDR_W:0]   frame_len;
  logic              frame_err;
  logic              valid;

  int checks = 0;
  int errors = 0;

  int ncyc = 0;
  int wr_count = 0;
  int valid_count = 0;
  int valid_at = -1;
  int last_wen_at = -1;
  logic [ADDR_W-1:0] rec_addr [256];
  logic [7:0]        rec_data [256];

  logic [7:0] bytes [32];
  int tlast_at = -1;

  eth_rx_frame_reader #(.ADDR_W(ADDR_W), .FILTER_TYPE(16'h0800)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .m_eth_hdr_valid           (hdr_valid),
    .m_eth_hdr_ready           (hdr_ready),
    .m_eth_dest_mac            (dest_mac),
    .m_eth_src_mac             (src_mac),
    .m_eth_type                (eth_type),
    .m_eth_payload_axis_tdata  (tdata),
    .m_eth_payload_axis_tvalid (tvalid),
    .m_eth_payload_axis_tready (tready),
    .m_eth_payload_axis_tlast  (tlast),
    .m_eth_payload_axis_tuser  (tuser),
    .buf_waddr                 (buf_waddr),
    .buf_wdata                 (buf_wdata),
    .buf_wen                   (buf_wen),
    .frame_dest_mac            (frame_dest_mac),
    .frame_src_mac             (frame_src_mac),
    .frame_type                (frame_type),
    .frame_len                 (frame_len),
    .frame_err                 (frame_err),
    .valid                     (valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    ncyc <= ncyc + 1;
    if (buf_wen) begin
      rec_addr[wr_count[7:0]] <= buf_waddr;
      rec_data[wr_count[7:0]] <= buf_wdata;
      last_wen_at <= ncyc;
      wr_count <= wr_count + 1;
    end
    if (valid) begin
      valid_at <= ncyc;
      valid_count <= valid_count + 1;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_bytes(input logic [7:0] start, input logic [7:0] step);
    for (int i = 0; i < 32; i++) bytes[i] = start + step * i[7:0];
  endtask

  // Called at posedge+1; returns at posedge+1 after the frame has drained.
  task automatic send_frame(input logic [15:0] typ, input int n, input bit gaps,
                            input bit err_last, input int rst_after);
    int t;
    dest_mac  = 48'h0200_0000_00AA;
    src_mac   = 48'h0200_0000_00BB;
    eth_type  = typ;
    hdr_valid = 1'b1;
    t = 0;
    while (!hdr_ready && t < 100) begin @(posedge clk); #1; t++; end
    if (t >= 100) check_val("hdr_timeout", 64'(t), 64'd0);
    @(posedge clk); #1;
    hdr_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == rst_after) begin
        tvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      if (gaps) begin
        tvalid = 1'b0;
        @(posedge clk); #1;
      end
      tdata  = bytes[i];
      tvalid = 1'b1;
      tlast  = (i == n - 1);
      tuser  = err_last && (i == n - 1);
      t = 0;
      while (!tready && t < 100) begin @(posedge clk); #1; t++; end
      if (t >= 100) check_val("beat_timeout", 64'(t), 64'd0);
      @(posedge clk); #1;
      if (i == n - 1) tlast_at = ncyc;
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    tuser  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string nm, input int wbase, input int vbase,
                             input int exp_wr, input int exp_len, input bit exp_err,
                             input int exp_valid);
    check_val({nm, ".writes"}, 64'(wr_count - wbase), 64'(exp_wr));
    for (int i = 0; i < exp_wr; i++) begin
      check_val($sformatf("%s.addr%0d", nm, i), 64'(rec_addr[wbase + i]), 64'(i));
      check_val($sformatf("%s.data%0d", nm, i), 64'(rec_data[wbase + i]), 64'(bytes[i]));
    end
    check_val({nm, ".len"}, 64'(frame_len), 64'(exp_len));
    check_val({nm, ".err"}, 64'(frame_err), 64'(exp_err));
    check_val({nm, ".valid_cnt"}, 64'(valid_count - vbase), 64'(exp_valid));
    if (exp_valid == 1) check_val({nm, ".valid_time"}, 64'(valid_at), 64'(tlast_at));
  endtask

  initial begin
    int wb, vb;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check_val("rst.hdr_ready", 64'(hdr_ready), 64'd1);
    check_val("rst.tready", 64'(tready), 64'd0);
    check_val("rst.wen", 64'(buf_wen), 64'd0);
    check_val("rst.valid", 64'(valid), 64'd0);
    check_val("rst.len", 64'(frame_len), 64'd0);
    check_val("rst.type", 64'(frame_type), 64'd0);
    check_val("rst.dest", frame_dest_mac, 64'd0);

    // Four bytes, tvalid held high.
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
    wb = wr_count; vb = valid_count;
    send_frame(16'h0800, 4, 1'b0, 1'b0, -1);
    check_frame("basic", wb, vb, 4, 4, 1'b0, 1);
    check_val("basic.last_wen_time", 64'(last_wen_at), 64'(tlast_at));
    check_val("basic.type", 64'(frame_type), 64'h0800);
    check_val("basic.dest", frame_dest_mac, 64'h0200_0000_00AA);
    check_val("basic.src", frame_src_mac, 64'h0200_0000_00BB);
    check_val("basic.hdr_ready_after", 64'(hdr_ready), 64'd1);

    // Same frame with a bubble before every beat.
    wb = wr_count; vb = valid_count;
    send_frame(16'h0800, 4, 1'b1, 1'b0, -1);
    check_frame("gaps", wb, vb, 4, 4, 1'b0, 1);
    check_val("gaps.last_wen_time", 64'(last_wen_at), 64'(tlast_at));

    // 20 bytes into a 16-byte buffer.
    fill_bytes(8'h40, 8'h01);
    wb = wr_count; vb = valid_count;
    send_frame(16'h0800, 20, 1'b0, 1'b0, -1);
    check_frame("ovf", wb, vb, 16, 16, 1'b1, 1);

    // tuser on the last beat.
    fill_bytes(8'h90, 8'h03);
    wb = wr_count; vb = valid_count;
    send_frame(16'h0800, 3, 1'b0, 1'b1, -1);
    check_frame("tuser", wb, vb, 3, 3, 1'b1, 1);

    // Reset after two of five bytes.
    fill_bytes(8'hC0, 8'h01);
    vb = valid_count;
    send_frame(16'h0800, 5, 1'b0, 1'b0, 2);
    check_val("midrst.hdr_ready", 64'(hdr_ready), 64'd1);
    check_val("midrst.wen", 64'(buf_wen), 64'd0);
    check_val("midrst.len", 64'(frame_len), 64'd0);
    check_val("midrst.err", 64'(frame_err), 64'd0);
    check_val("midrst.type", 64'(frame_type), 64'd0);
    check_val("midrst.src", frame_src_mac, 64'd0);
    check_val("midrst.valid_cnt", 64'(valid_count - vb), 64'd0);
    fill_bytes(8'hA0, 8'h05);
    wb = wr_count; vb = valid_count;
    send_frame(16'h0800, 3, 1'b0, 1'b0, -1);
    check_frame("postrst", wb, vb, 3, 3, 1'b0, 1);

`ifdef ETH_RX_TYPE_FILTER_EN
    fill_bytes(8'h10, 8'h07);
    wb = wr_count; vb = valid_count;
    send_frame(16'h86DD, 5, 1'b0, 1'b0, -1);
    check_val("filt.writes", 64'(wr_count - wb), 64'd0);
    check_val("filt.valid_cnt", 64'(valid_count - vb), 64'd0);
    check_val("filt.type", 64'(frame_type), 64'h0800);
    check_val("filt.len", 64'(frame_len), 64'd3);
    check_val("filt.hdr_ready", 64'(hdr_ready), 64'd1);
    fill_bytes(8'h55, 8'h02);
    wb = wr_count; vb = valid_count;
    send_frame(16'h0800, 4, 1'b0, 1'b0, -1);
    check_frame("afterfilt", wb, vb, 4, 4, 1'b0, 1);
`else
    fill_bytes(8'h10, 8'h07);
    wb = wr_count; vb = valid_count;
    send_frame(16'h86DD, 5, 1'b0, 1'b0, -1);
    check_frame("v6", wb, vb, 5, 5, 1'b0, 1);
    check_val("v6.type", 64'(frame_type), 64'h86DD);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got %0d expected %0d", 0, 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/eth_rx_frame_reader.md
Name: eth_rx_frame_reader

Overview:
- Receive-side counterpart of the byte-writer functions that drive an eth_axis_tx-style slave port.
- Accepts one Ethernet frame from an eth_axis_rx-style master port: a header handshake followed by an 8-bit AXI-stream payload.
- Latches the header fields, writes payload bytes sequentially into a byte RAM and reports frame length and status.
- Sits between the MAC/eth_axis_rx core and HLS-generated consumer functions that read the byte RAM.

Parameters:
- ADDR_W, 8: byte RAM address width; buffer capacity is 2^ADDR_W bytes.
- FILTER_TYPE, 16'h0800: EtherType accepted when the filter feature is compiled in.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- m_eth_hdr_valid  in  1  header valid
- m_eth_hdr_ready  out  1  header ready
- m_eth_dest_mac  in  48  destination MAC
- m_eth_src_mac  in  48  source MAC
- m_eth_type  in  16  EtherType
- m_eth_payload_axis_tdata  in  8  payload byte
- m_eth_payload_axis_tvalid  in  1  payload valid
- m_eth_payload_axis_tready  out  1  payload ready
- m_eth_payload_axis_tlast  in  1  last payload byte
- m_eth_payload_axis_tuser  in  1  frame error flag (sampled on the last beat)
- buf_waddr  out  ADDR_W  byte RAM write address
- buf_wdata  out  8  byte RAM write data
- buf_wen  out  1  byte RAM write enable
- frame_dest_mac  out  48  latched destination MAC
- frame_src_mac  out  48  latched source MAC
- frame_type  out  16  latched EtherType
- frame_len  out  ADDR_W+1  number of bytes stored
- frame_err  out  1  frame had tuser set or overflowed
- valid  out  1  frame-complete pulse

Behaviour:
- Reset values: all outputs 0; state WAIT_HDR; byte counter 0.
- FSM states: WAIT_HDR, RECV, DROP, DONE.
- WAIT_HDR:
  - m_eth_hdr_ready=1, tready=0.
  - On hdr_valid&hdr_ready: latch dest_mac, src_mac and type into the frame_* outputs; clear counter and err; go to RECV next cycle.
- RECV:
  - hdr_ready=0, tready=1.
  - Each accepted beat (tvalid&tready) registers one write in the next cycle: buf_wen=1, buf_waddr=counter, buf_wdata=tdata. The counter then increments.
  - buf_wen is 0 in any cycle that follows a non-beat cycle.
  - A tlast beat moves the FSM to DONE.
  - A beat arriving when counter==2^ADDR_W is not written. It sets err and moves the FSM to DROP, unless it carries tlast, in which case the FSM goes to DONE.
- DROP:
  - tready=1; beats are discarded with no writes.
  - The tlast beat moves the FSM to DONE.
- Counter width is ADDR_W+1 and it saturates at 2^ADDR_W; frame_len equals the saturated counter.
- tuser=1 on the tlast beat sets frame_err; the data is still stored.
- DONE:
  - Entered in cycle N+1, where N is the cycle of the tlast handshake; the final buf_wen pulse occurs in N+1.
  - valid=1 for exactly one cycle in N+1, with frame_len and frame_err stable.
  - Return to WAIT_HDR at N+2.
  - frame_* outputs hold until the next header is accepted.
- A header offered while not in WAIT_HDR waits, since hdr_ready=0.
- Reset mid-frame: the FSM returns to WAIT_HDR next cycle with all outputs 0. The remainder of the interrupted stream is consumed as a new frame only after a new header.
- Zero-length frames are impossible; a tlast on the first beat gives frame_len=1.

Optional Feature:
- Macro: ETH_RX_TYPE_FILTER_EN.
- Defined: in WAIT_HDR, a header with m_eth_type != FILTER_TYPE is accepted but goes to DROP with a filter flag. The whole payload is consumed with no writes. At tlast the FSM returns straight to WAIT_HDR: no valid pulse, frame_* outputs unchanged.
- Undefined: every EtherType is received normally.

Test Plan:
- Header (type 0x0800) then 4 bytes 0x11,0x22,0x33,0x44, tlast on the 4th, tvalid held high -> buf_wen pulses at addresses 0..3 with those bytes; valid one cycle after the last handshake; frame_len=4; frame_err=0.
- Same frame with tvalid gaps (every other cycle) -> identical RAM contents; valid asserted exactly 1 cycle after the tlast handshake.
- ADDR_W=4, 20-byte frame -> 16 writes (addresses 0..15); bytes 17..20 dropped; frame_len=16; frame_err=1; valid once.
- 3-byte frame with tuser=1 on tlast -> 3 writes; frame_len=3; frame_err=1.
- rst asserted after 2 of 5 bytes -> next cycle state WAIT_HDR, hdr_ready=1, all outputs 0; a following clean frame is received correctly from address 0.
- With ETH_RX_TYPE_FILTER_EN, header type 0x86DD plus 5 bytes -> tready held high, no buf_wen, no valid; next 0x0800 frame is received normally.
